// File: rtl/thermal_pid_pwm_core.sv
`default_nettype none
// ============================================================================
// Module   : thermal_pid_pwm_core
// Brief    : Fixed-latency sequential PID driving mutually exclusive heater/fan PWM.
// Revision : 1.0 - initial release
// ============================================================================
module thermal_pid_pwm_core #(
    parameter int DATA_W     = 16,
    parameter int OUT_W      = 8,
    parameter int KP         = 4,
    parameter int KI         = 1,
    parameter int KD         = 2,
    parameter int GAIN_SHIFT = 4,
    parameter int I_LIMIT    = 4096,
    parameter int DEADBAND   = 25,
    parameter int PWM_DIV    = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] temp_in,
    input  logic [DATA_W-1:0] set_in,
    output logic              busy,
    output logic              cmd_valid,
    output logic [OUT_W-1:0]  cmd_mag,
    output logic              cmd_heat,
    output logic              sat,
    output logic              pwm_heat,
    output logic              pwm_fan
);
    localparam int c_EW    = DATA_W + 1;
    localparam int c_IW    = DATA_W + 2;
    localparam int c_SW    = 2 * DATA_W + 4;
    localparam int c_PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_ERR  = 3'd1;
    localparam logic [2:0] c_ST_INT  = 3'd2;
    localparam logic [2:0] c_ST_SUM  = 3'd3;
    localparam logic [2:0] c_ST_OUT  = 3'd4;

    localparam logic        [c_EW-1:0]    c_DEADBAND = c_EW'(DEADBAND);
    localparam logic signed [c_IW-1:0]    c_ILIM_P   = c_IW'(I_LIMIT);
    localparam logic signed [c_IW-1:0]    c_ILIM_N   = -c_ILIM_P;
    localparam logic signed [c_SW-1:0]    c_KP       = c_SW'(KP);
    localparam logic signed [c_SW-1:0]    c_KI       = c_SW'(KI);
    localparam logic signed [c_SW-1:0]    c_KD       = c_SW'(KD);
    localparam logic        [c_SW-1:0]    c_MAG_MAX  = c_SW'((2 ** OUT_W) - 1);
    localparam logic        [OUT_W-1:0]   c_CNT_LAST = OUT_W'((2 ** OUT_W) - 2);
    localparam logic        [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(PWM_DIV - 1);

    logic [2:0]              r_state, w_next;
    logic [DATA_W-1:0]       r_temp, r_set;
    logic signed [c_EW-1:0]  r_err, r_prev, r_int;
    logic signed [c_IW-1:0]  r_deriv;
    logic signed [c_SW-1:0]  r_sum;
    logic                    r_busy, r_cmd_valid, r_cmd_heat, r_sat;
    logic [OUT_W-1:0]        r_cmd_mag;

    logic                    w_accept;
    logic signed [c_EW-1:0]  w_diff;
    logic [c_EW-1:0]         w_diff_mag;
    logic signed [c_IW-1:0]  w_int_sum, w_int_clamped;
    logic signed [c_SW-1:0]  w_s;
    logic [c_SW-1:0]         w_s_mag;

    logic [c_PRE_W-1:0]      r_pre;
    logic [OUT_W-1:0]        r_cnt, r_mag;
    logic                    r_dir;
    logic                    w_tick, w_wrap;

    assign w_accept   = en && sample_valid && (r_state == c_ST_IDLE) && !r_busy;
    assign w_diff     = $signed({1'b0, r_set}) - $signed({1'b0, r_temp});
    assign w_diff_mag = w_diff[c_EW-1] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign w_int_sum  = c_IW'(r_int) + c_IW'(r_err);
    assign w_s        = r_sum >>> GAIN_SHIFT;
    assign w_s_mag    = w_s[c_SW-1] ? $unsigned(-w_s) : $unsigned(w_s);

    always_comb begin
        w_int_clamped = w_int_sum;
        if (w_int_sum > c_ILIM_P) begin
            w_int_clamped = c_ILIM_P;
        end else if (w_int_sum < c_ILIM_N) begin
            w_int_clamped = c_ILIM_N;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept) w_next = c_ST_ERR;
            c_ST_ERR:  w_next = c_ST_INT;
            c_ST_INT:  w_next = c_ST_SUM;
            c_ST_SUM:  w_next = c_ST_OUT;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // busy also spans the cmd_valid cycle, so a strobe there is dropped too
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_temp      <= '0;
            r_set       <= '0;
            r_err       <= '0;
            r_prev      <= '0;
            r_int       <= '0;
            r_deriv     <= '0;
            r_sum       <= '0;
            r_busy      <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_mag   <= '0;
            r_cmd_heat  <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            r_busy      <= (w_next != c_ST_IDLE) || (r_state == c_ST_OUT);
            r_cmd_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_temp <= temp_in;
                        r_set  <= set_in;
                    end
                end
                c_ST_ERR: begin
                    r_err <= (w_diff_mag <= c_DEADBAND) ? '0 : w_diff;
                end
                c_ST_INT: begin
                    if (r_err != '0) begin
                        r_int <= w_int_clamped[c_EW-1:0];
                    end
                    r_deriv <= c_IW'(r_err) - c_IW'(r_prev);
                    r_prev  <= r_err;
                end
                c_ST_SUM: begin
                    r_sum <= c_KP * c_SW'(r_err) + c_KI * c_SW'(r_int) + c_KD * c_SW'(r_deriv);
                end
                c_ST_OUT: begin
                    r_cmd_valid <= 1'b1;
                    r_sat       <= (w_s_mag > c_MAG_MAX);
                    r_cmd_mag   <= (w_s_mag > c_MAG_MAX) ? '1 : w_s_mag[OUT_W-1:0];
                    r_cmd_heat  <= !w_s[c_SW-1] && (w_s != '0);
                end
                default: ;
            endcase
        end
    end

    // Prescaler free-runs through en=0 so tick phase only resets with rst
    assign w_tick = (r_pre == c_PRE_LAST);
    assign w_wrap = w_tick && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_PRE_W'(1);
        end
    end

    // A reversal while driving inserts one all-off period; an idle output reverses at once
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_cnt <= '0;
            r_mag <= '0;
            r_dir <= 1'b0;
        end else if (w_tick) begin
            r_cnt <= w_wrap ? '0 : r_cnt + OUT_W'(1);
            if (w_wrap) begin
                r_mag <= ((r_mag != '0) && (r_cmd_heat != r_dir)) ? '0 : r_cmd_mag;
                r_dir <= r_cmd_heat;
            end
        end
    end

    assign busy      = r_busy;
    assign cmd_valid = r_cmd_valid;
    assign cmd_mag   = r_cmd_mag;
    assign cmd_heat  = r_cmd_heat;
    assign sat       = r_sat;
    assign pwm_heat  = r_dir && (r_cnt < r_mag);
    assign pwm_fan   = !r_dir && (r_cnt < r_mag);

endmodule
`default_nettype wire

// File: tb/tb_thermal_pid_pwm_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_thermal_pid_pwm_core
// Brief    : Directed and random stimulus against a per-cycle behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_thermal_pid_pwm_core;
    localparam int DATA_W     = 16;
    localparam int OUT_W      = 8;
    localparam int KP         = 4;
    localparam int KI         = 1;
    localparam int KD         = 2;
    localparam int GAIN_SHIFT = 4;
    localparam int I_LIMIT    = 4096;
    localparam int DEADBAND   = 25;
    localparam int PWM_DIV    = 2;
    localparam int PMAX       = (1 << OUT_W) - 1;

    logic              clk = 1'b0;
    logic              rst, en, sample_valid;
    logic [DATA_W-1:0] temp_in, set_in;
    logic              busy, cmd_valid, cmd_heat, sat, pwm_heat, pwm_fan;
    logic [OUT_W-1:0]  cmd_mag;

    always #5 clk = ~clk;

    thermal_pid_pwm_core #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .KP(KP), .KI(KI), .KD(KD),
        .GAIN_SHIFT(GAIN_SHIFT), .I_LIMIT(I_LIMIT), .DEADBAND(DEADBAND), .PWM_DIV(PWM_DIV)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sample_valid(sample_valid),
        .temp_in(temp_in), .set_in(set_in), .busy(busy), .cmd_valid(cmd_valid),
        .cmd_mag(cmd_mag), .cmd_heat(cmd_heat), .sat(sat),
        .pwm_heat(pwm_heat), .pwm_fan(pwm_fan)
    );

    int checks = 0;
    int errors = 0;
    int nprint = 0;

    // Model state: e is the index of the most recent rising edge
    bit m_live = 1'b0;
    int e = 0;
    int m_int, m_prev, m_cap;
    int p_mag;
    bit p_heat, p_sat;
    int x_mag;
    bit x_heat, x_sat, x_valid;
    int m_k, m_ticks, a_mag;
    bit a_dir;

    task automatic model_eval(input int sp, input int tp);
        int err, der, sum, q, qa, div;
        div = 1 << GAIN_SHIFT;
        err = sp - tp;
        if (err <= DEADBAND && err >= -DEADBAND) err = 0;
        if (err != 0) begin
            m_int = m_int + err;
            if (m_int > I_LIMIT)  m_int = I_LIMIT;
            if (m_int < -I_LIMIT) m_int = -I_LIMIT;
        end
        der    = err - m_prev;
        m_prev = err;
        sum    = KP * err + KI * m_int + KD * der;
        if (sum >= 0) q = sum / div;
        else          q = -((-sum + div - 1) / div);
        qa     = (q < 0) ? -q : q;
        p_sat  = (qa > PMAX);
        p_mag  = p_sat ? PMAX : qa;
        p_heat = (q > 0);
    endtask

    task automatic model_clear();
        m_int = 0; m_prev = 0; m_cap = -100;
        x_mag = 0; x_heat = 1'b0; x_sat = 1'b0; x_valid = 1'b0;
        m_ticks = 0; a_mag = 0; a_dir = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        e = e + 1;
        if (rst) begin
            m_live = 1'b1;
            m_k    = 0;
            model_clear();
        end else begin
            m_k = m_k + 1;
            if (!en) begin
                model_clear();
            end else begin
                if (m_k % PWM_DIV == 0) begin
                    m_ticks = m_ticks + 1;
                    if (m_ticks % PMAX == 0) begin
                        if (a_mag != 0 && x_heat != a_dir) a_mag = 0;
                        else                               a_mag = x_mag;
                        a_dir = x_heat;
                    end
                end
                x_valid = 1'b0;
                if (m_cap >= 0 && e == m_cap + 4) begin
                    x_mag = p_mag; x_heat = p_heat; x_sat = p_sat; x_valid = 1'b1;
                end
                if (sample_valid && e >= m_cap + 6) begin
                    model_eval(int'(set_in), int'(temp_in));
                    m_cap = e;
                end
            end
        end
    end

    int          c_pos;
    bit          c_eh, c_ef, c_busy;
    logic [13:0] c_exp, c_act;

    initial forever begin
        @(negedge clk);
        if (m_live) begin
            c_pos  = m_ticks % PMAX;
            c_eh   = a_dir && (c_pos < a_mag);
            c_ef   = !a_dir && (c_pos < a_mag);
            c_busy = (m_cap >= 0) && (e >= m_cap) && (e <= m_cap + 4);
            c_exp  = {c_busy, x_valid, 8'(x_mag), x_heat, x_sat, c_eh, c_ef};
            c_act  = {busy, cmd_valid, cmd_mag, cmd_heat, sat, pwm_heat, pwm_fan};
            checks = checks + 1;
            if (c_act !== c_exp) begin
                errors = errors + 1;
                if (nprint < 20)
                    $display("FAIL cycle_compare edge %0d: dut {busy,valid,mag,heat,sat,ph,pf}=%b model=%b",
                             e, c_act, c_exp);
                nprint = nprint + 1;
            end
            checks = checks + 1;
            if (pwm_heat && pwm_fan) begin
                errors = errors + 1;
                $display("FAIL pwm_overlap edge %0d: pwm_heat=1 pwm_fan=1", e);
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_cmd(input string nm, input int sp, input int tp,
                           input int em, input int eh, input int es);
        int lat;
        bit got;
        set_in = 16'(sp); temp_in = 16'(tp); sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        lat = 0; got = 1'b0;
        while (!got && lat < 10) begin
            if (cmd_valid) got = 1'b1;
            else begin
                @(negedge clk);
                lat = lat + 1;
            end
        end
        check({nm, "_latency"}, got ? lat : -1, 4);
        check({nm, "_mag"}, int'(cmd_mag), em);
        check({nm, "_heat"}, int'(cmd_heat), eh);
        check({nm, "_sat"}, int'(sat), es);
    endtask

    task automatic count_pwm(input int n, output int hc, output int fc);
        hc = 0; fc = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hc = hc + int'(pwm_heat);
            fc = fc + int'(pwm_fan);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    int hc, fc, nv, sp;

    initial begin
        rst = 1'b1; en = 1'b0; sample_valid = 1'b0; set_in = '0; temp_in = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({busy, cmd_valid, cmd_mag, cmd_heat, sat, pwm_heat, pwm_fan}), 0);
        rst = 1'b0; en = 1'b1;
        @(negedge clk);

        run_cmd("first", 3000, 2500, 218, 1, 0);
        tick_n(3);
        run_cmd("repeat", 3000, 2500, 187, 1, 0);

        do_reset();
        run_cmd("deadband", 3000, 2990, 0, 0, 0);
        count_pwm(520, hc, fc);
        check("deadband_heat_ticks", hc, 0);
        check("deadband_fan_ticks", fc, 0);

        run_cmd("saturate", 9000, 1000, 255, 1, 1);
        tick_n(515);
        count_pwm(PMAX * PWM_DIV, hc, fc);
        check("saturate_heat_cycles", hc, PMAX * PWM_DIV);
        check("saturate_fan_cycles", fc, 0);

        do_reset();
        run_cmd("cool", 2000, 2500, 219, 0, 0);
        tick_n(515);
        count_pwm(PMAX * PWM_DIV, hc, fc);
        check("cool_fan_cycles", fc, 219 * PWM_DIV);
        check("cool_heat_cycles", hc, 0);

        // integral -500 + err 500 -> 0, deriv 1000: sum 4000 -> 250 heating
        run_cmd("reverse", 3000, 2500, 250, 1, 0);
        count_pwm(PMAX * PWM_DIV, hc, fc);
        check("reverse_no_heat_first_period", hc, 0);
        tick_n(PMAX * PWM_DIV);
        count_pwm(PMAX * PWM_DIV, hc, fc);
        check("reverse_heat_cycles", hc, 250 * PWM_DIV);
        check("reverse_fan_cycles", fc, 0);

        set_in = 16'd3000; temp_in = 16'd2500; sample_valid = 1'b1;
        nv = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            sample_valid = (k == 1 || k == 3);
            nv = nv + int'(cmd_valid);
        end
        check("dropped_strobes_valid_count", nv, 1);

        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        en = 1'b0;
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            nv = nv + int'(cmd_valid);
        end
        check("abort_valid_count", nv, 0);
        check("abort_outputs", int'({cmd_mag, cmd_heat, sat, pwm_heat, pwm_fan}), 0);
        en = 1'b1;
        @(negedge clk);
        run_cmd("after_abort", 3000, 2500, 218, 1, 0);

        tick_n(2);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        tick_n(1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_sum_outputs",
              int'({busy, cmd_valid, cmd_mag, cmd_heat, sat, pwm_heat, pwm_fan}), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 799) == 0);
            if (en) begin
                if ($urandom_range(0, 299) == 0) en = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                en = 1'b1;
            end
            sample_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                set_in  = 16'($urandom_range(0, 65535));
                temp_in = 16'($urandom_range(0, 65535));
            end else begin
                sp      = int'($urandom_range(1000, 6000));
                set_in  = 16'(sp);
                temp_in = 16'(sp + int'($urandom_range(0, 800)) - 400);
            end
        end
        rst = 1'b0; sample_valid = 1'b0;
        tick_n(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/thermal_pid_pwm_core.md
Name: thermal_pid_pwm_core

Overview:
Parametrised closed-loop actuator core for the temperature controller. It replaces the ad-hoc PID plus two PWM drivers with sign muxing by a single block. Each accepted sensor sample (temperature ×100) runs a fixed-latency, sequential PID evaluation against the setpoint. The signed result drives two mutually exclusive PWM outputs, heater and fan, with a deadband, anti-windup, saturation flag and glitch-free duty updates.

Parameters:
DATA_W, 16, width of temp_in/set_in (unsigned, °C ×100)
OUT_W, 8, PWM magnitude width; PWM period = 2^OUT_W-1 ticks
KP, 4, proportional gain (unsigned integer)
KI, 1, integral gain
KD, 2, derivative gain
GAIN_SHIFT, 4, arithmetic right shift applied to PID sum
I_LIMIT, 4096, integral clamp magnitude (±I_LIMIT)
DEADBAND, 25, |error| at or below this is treated as zero
PWM_DIV, 100, clk cycles per PWM tick (≥1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en  in  1  control enable (setpoint valid)
sample_valid  in  1  one-cycle strobe, new temp_in available
temp_in  in  DATA_W  measured temperature ×100
set_in  in  DATA_W  setpoint ×100
busy  out  1  PID evaluation in progress
cmd_valid  out  1  one-cycle strobe, new command latched
cmd_mag  out  OUT_W  command magnitude
cmd_heat  out  1  1 = heat, 0 = cool
sat  out  1  last command was clamped
pwm_heat  out  1  heater PWM
pwm_fan  out  1  fan PWM

Behaviour:
- Reset (rst=1 at clk edge): FSM=IDLE; integral, prev_err, cmd_mag, cmd_heat, sat, busy, cmd_valid = 0; PWM counters = 0; pwm_heat = pwm_fan = 0. rst has priority over everything.
- en=0: same clearing as reset except PWM prescaler keeps running; samples are ignored. An evaluation in progress is aborted.
- FSM: IDLE -> ERR -> INT -> SUM -> OUT -> IDLE.
  - IDLE: with en & sample_valid, capture temp_in and set_in (edge N).
  - ERR: err = set - temp, signed DATA_W+1 bits. If |err| ≤ DEADBAND then err = 0.
  - INT: if err≠0 then integral = clamp(integral+err, ±I_LIMIT), else integral unchanged. deriv = err - prev_err. prev_err = err.
  - SUM: sum = KP*err + KI*integral + KD*deriv, signed, at least 2*DATA_W+4 bits, no overflow.
  - OUT: s = sum >>> GAIN_SHIFT (arithmetic, floors toward -inf). cmd_mag = min(|s|, 2^OUT_W-1). sat = (|s| > 2^OUT_W-1). cmd_heat = (s > 0). Assert cmd_valid.
- Latency: cmd_valid is high exactly one cycle, 4 cycles after the capture edge. busy is high from capture+1 through the cmd_valid cycle.
- sample_valid while busy is dropped; there is no queueing.
- PWM:
  - Prescaler counts 0..PWM_DIV-1. A tick occurs on wrap.
  - Period counter advances per tick over 0..2^OUT_W-2.
  - Active duty registers (mag, dir) load from cmd_mag/cmd_heat only at period wrap (counter 254→0 at OUT_W=8).
  - pwm_heat = dir & (cnt < mag); pwm_fan = ~dir & (cnt < mag).
  - mag = 2^OUT_W-1 gives constant on; mag = 0 gives constant off.
- Direction change: when the pending dir differs from the active dir at a period wrap, one full period runs with mag forced to 0 (both outputs low), then the new command loads.
- Invariant: pwm_heat & pwm_fan is never 1.

Test Plan:
- Reset, then en=1, set=3000, temp=2500 strobe -> cmd_valid 4 cycles later; cmd_mag=218, cmd_heat=1, sat=0. Repeat the same sample -> cmd_mag=187 (integral 1000, deriv 0).
- After reset: set=3000, temp=2990 -> err zeroed, cmd_mag=0; pwm_heat and pwm_fan stay 0 for a full period.
- set=9000, temp=1000 -> integral clamps to 4096, sum=52096, cmd_mag=255, sat=1. With PWM_DIV=2, pwm_heat stays high for the whole 255-tick period after the next wrap.
- After reset: set=2000, temp=2500 -> s=-219, cmd_mag=219, cmd_heat=0. pwm_fan is high for 219 of 255 ticks; pwm_heat stays 0.
- Heat command active, then a cool command -> at the next wrap, one period with both outputs low, then pwm_fan follows. Assert pwm_heat & pwm_fan never overlap.
- sample_valid pulses at capture+2 and mid-OUT -> ignored, single cmd_valid. Drop en during INT -> no cmd_valid, outputs 0, integral 0. rst mid-SUM -> all outputs 0 next cycle.
